// File: rtl/clk_div_prog_pkg.sv
// Shared types and helpers for the programmable clock divider.
package clk_div_prog_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_e;

    localparam int unsigned DIV_MIN = 2;
    localparam int unsigned CALC_W  = 32;

    // Ratios 0 and 1 cannot form a clock period, so they map to the minimum.
    function automatic logic [CALC_W-1:0] clamp_div(input logic [CALC_W-1:0] n);
        return (n < CALC_W'(DIV_MIN)) ? CALC_W'(DIV_MIN) : n;
    endfunction

    // Length of the high phase: ceil(n/2).
    function automatic logic [CALC_W-1:0] hi_len(input logic [CALC_W-1:0] n);
        return (n >> 1) + CALC_W'(n[0]);
    endfunction

endpackage

// File: rtl/clk_div_prog_cnt.sv
// Period counter: wraps at i_div-1 and derives the divided-clock phase.
module clk_div_prog_cnt
    import clk_div_prog_pkg::*;
#(
    parameter int unsigned DIV_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_start,
    input  logic             i_adv,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_wrap_c,
    output logic             o_phase_nxt_c
);

    logic [DIV_W-1:0] r_cnt;
    logic             r_phase;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [DIV_W-1:0] w_hi;

    always_comb begin
        w_hi          = DIV_W'(hi_len(CALC_W'(i_div)));
        o_wrap_c      = (r_cnt == (i_div - DIV_W'(1)));
        w_cnt_nxt     = r_cnt;
        o_phase_nxt_c = r_phase;
        if (i_clr) begin
            w_cnt_nxt     = '0;
            o_phase_nxt_c = 1'b0;
        end else if (i_start) begin
            w_cnt_nxt     = '0;
            o_phase_nxt_c = 1'b1;
        end else if (i_adv) begin
            w_cnt_nxt     = o_wrap_c ? '0 : r_cnt + DIV_W'(1);
            o_phase_nxt_c = (w_cnt_nxt < w_hi);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_phase <= o_phase_nxt_c;
        end
    end

endmodule

// File: rtl/clk_div_prog.sv
// Glitch-free programmable integer clock divider with boundary-aligned updates.
// Optional o_tick clock-enable output when CLK_DIV_PROG_TICK_EN is defined.
module clk_div_prog
    import clk_div_prog_pkg::*;
#(
    parameter int unsigned DIV_W   = 8,
    parameter int unsigned RST_DIV = 2,
    parameter bit          RST_INV = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_div_valid,
    output logic             o_div_ack,
    input  logic             i_inv,
    output logic             o_busy,
    output logic             o_clk
`ifdef CLK_DIV_PROG_TICK_EN
    ,
    output logic             o_tick
`endif
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [DIV_W-1:0] r_div_act;
    logic [DIV_W-1:0] r_div_nxt;
    logic             r_inv;
    logic             r_pending;

    logic             w_start;
    logic             w_adv;
    logic             w_clr;
    logic             w_apply;
    logic             w_inv_load;
    logic             w_inv_nxt;
    logic             w_wrap;
    logic             w_phase_nxt;
    logic [DIV_W-1:0] w_div_clamped;

    clk_div_prog_cnt #(
        .DIV_W (DIV_W)
    ) u_cnt (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_clr         (w_clr),
        .i_start       (w_start),
        .i_adv         (w_adv),
        .i_div         (r_div_act),
        .o_wrap_c      (w_wrap),
        .o_phase_nxt_c (w_phase_nxt)
    );

    assign w_div_clamped = DIV_W'(clamp_div(CALC_W'(i_div)));
    assign w_inv_nxt     = w_inv_load ? i_inv : r_inv;
    assign o_busy        = r_pending;

    // Next-state and control: ratio/polarity only change on period boundaries.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_adv       = 1'b0;
        w_clr       = 1'b0;
        w_apply     = 1'b0;
        w_inv_load  = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_inv_load = 1'b1;
                w_apply    = r_pending;
                if (i_en) begin
                    w_state_nxt = RUN;
                    w_start     = 1'b1;
                end else begin
                    w_clr = 1'b1;
                end
            end
            RUN: begin
                w_adv = 1'b1;
                if (w_wrap) begin
                    w_apply    = r_pending;
                    w_inv_load = 1'b1;
                end
                if (!i_en) begin
                    w_state_nxt = STOPPING;
                end
            end
            STOPPING: begin
                w_adv = 1'b1;
                if (w_wrap) begin
                    w_apply    = r_pending;
                    w_inv_load = 1'b1;
                end
                if (i_en) begin
                    w_state_nxt = RUN;
                end else if (w_wrap) begin
                    w_state_nxt = IDLE;
                    w_adv       = 1'b0;
                    w_clr       = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_clr       = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // o_clk is a single flop so simultaneous phase/polarity changes cannot glitch.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div_act <= DIV_W'(RST_DIV);
            r_div_nxt <= DIV_W'(RST_DIV);
            r_inv     <= RST_INV;
            r_pending <= 1'b0;
            o_div_ack <= 1'b0;
            o_clk     <= RST_INV;
        end else begin
            o_div_ack <= w_apply;
            o_clk     <= w_phase_nxt ^ w_inv_nxt;
            r_inv     <= w_inv_nxt;
            if (w_apply) begin
                r_div_act <= r_div_nxt;
                r_pending <= 1'b0;
            end
            if (i_div_valid && !r_pending) begin
                r_div_nxt <= w_div_clamped;
                r_pending <= 1'b1;
            end
        end
    end

`ifdef CLK_DIV_PROG_TICK_EN
    logic r_phase;

    // Tick marks the cycle in which the phase rises.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_phase <= 1'b0;
            o_tick  <= 1'b0;
        end else begin
            r_phase <= w_phase_nxt;
            o_tick  <= w_phase_nxt & ~r_phase;
        end
    end
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed, table-driven bench for clk_div_prog.
module tb_clk_div_prog;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_en;
    logic [7:0] i_div;
    logic       i_div_valid;
    logic       o_div_ack;
    logic       i_inv;
    logic       o_busy;
    logic       o_clk;
`ifdef CLK_DIV_PROG_TICK_EN
    logic       o_tick;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] div;
        logic       inv;
        int         hi;
        int         lo;
    } vec_t;

    vec_t vecs [8];

    clk_div_prog dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_en        (i_en),
        .i_div       (i_div),
        .i_div_valid (i_div_valid),
        .o_div_ack   (o_div_ack),
        .i_inv       (i_inv),
        .o_busy      (o_busy),
        .o_clk       (o_clk)
`ifdef CLK_DIV_PROG_TICK_EN
        ,
        .o_tick      (o_tick)
`endif
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Checks nper full periods starting from the current cnt=0 cycle.
    task automatic measure(input int hi, input int lo, input logic inv, input int nper);
        logic e;
        for (int p = 0; p < nper; p++) begin
            for (int c = 0; c < hi + lo; c++) begin
                e = (c < hi) ^ inv;
                chk("run_o_clk", o_clk, e);
`ifdef CLK_DIV_PROG_TICK_EN
                chk("run_o_tick", o_tick, (c == 0));
`endif
                step();
            end
        end
    endtask

    // Drops i_en at cnt=0; the period must finish, then o_clk rests at inv.
    task automatic stop_check(input int hi, input int lo, input logic inv);
        logic e;
        i_en = 1'b0;
        for (int c = 0; c < hi + lo; c++) begin
            e = (c < hi) ^ inv;
            chk("stop_o_clk", o_clk, e);
            step();
        end
        chk("idle_o_clk", o_clk, inv);
        chk("idle_busy", o_busy, 1'b0);
    endtask

    task automatic write_idle(input logic [7:0] div, input logic inv);
        i_inv       = inv;
        i_div       = div;
        i_div_valid = 1'b1;
        step();
        i_div_valid = 1'b0;
        chk("wr_busy_set", o_busy, 1'b1);
        chk("wr_ack_early", o_div_ack, 1'b0);
        chk("wr_idle_o_clk", o_clk, inv);
        step();
        chk("wr_ack", o_div_ack, 1'b1);
        chk("wr_busy_clr", o_busy, 1'b0);
        step();
        chk("wr_ack_pulse", o_div_ack, 1'b0);
    endtask

    initial begin
        logic e;
        vecs[0] = '{div: 8'd2,   inv: 1'b0, hi: 1,   lo: 1};
        vecs[1] = '{div: 8'd5,   inv: 1'b0, hi: 3,   lo: 2};
        vecs[2] = '{div: 8'd0,   inv: 1'b0, hi: 1,   lo: 1};
        vecs[3] = '{div: 8'd1,   inv: 1'b1, hi: 1,   lo: 1};
        vecs[4] = '{div: 8'd6,   inv: 1'b1, hi: 3,   lo: 3};
        vecs[5] = '{div: 8'd7,   inv: 1'b0, hi: 4,   lo: 3};
        vecs[6] = '{div: 8'd255, inv: 1'b0, hi: 128, lo: 127};
        vecs[7] = '{div: 8'd3,   inv: 1'b1, hi: 2,   lo: 1};

        i_rst = 1'b1; i_en = 1'b0; i_div = 8'd0; i_div_valid = 1'b0; i_inv = 1'b0;
        repeat (3) step();
        chk("rst_o_clk", o_clk, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_ack", o_div_ack, 1'b0);
        i_rst = 1'b0;
        step();
        chk("post_rst_o_clk", o_clk, 1'b0);

        // Reset ratio of 2, first high phase one cycle after i_en.
        i_en = 1'b1;
        step();
        measure(1, 1, 1'b0, 3);
        stop_check(1, 1, 1'b0);

        for (int v = 0; v < 8; v++) begin
            write_idle(vecs[v].div, vecs[v].inv);
            i_en = 1'b1;
            step();
            measure(vecs[v].hi, vecs[v].lo, vecs[v].inv, 2);
            stop_check(vecs[v].hi, vecs[v].lo, vecs[v].inv);
        end

        // Update N=4 -> 7 mid-period; a second request while busy is ignored.
        write_idle(8'd4, 1'b0);
        i_en = 1'b1;
        step();
        chk("a_cnt0", o_clk, 1'b1);
        step();
        chk("a_cnt1", o_clk, 1'b1);
        i_div = 8'd7; i_div_valid = 1'b1;
        step();
        i_div = 8'd3;
        chk("a_busy2", o_busy, 1'b1);
        chk("a_ack2", o_div_ack, 1'b0);
        chk("a_cnt2", o_clk, 1'b0);
        step();
        i_div_valid = 1'b0;
        chk("a_busy3", o_busy, 1'b1);
        chk("a_ack3", o_div_ack, 1'b0);
        chk("a_cnt3", o_clk, 1'b0);
        step();
        chk("a_ack_bnd", o_div_ack, 1'b1);
        chk("a_busy_bnd", o_busy, 1'b0);
        measure(4, 3, 1'b0, 2);
        stop_check(4, 3, 1'b0);

        // Polarity change mid-period waits for the boundary.
        write_idle(8'd6, 1'b0);
        i_en = 1'b1;
        step();
        for (int c = 0; c < 6; c++) begin
            e = (c < 3);
            chk("b_o_clk", o_clk, e);
            if (c == 2) i_inv = 1'b1;
            step();
        end
        measure(3, 3, 1'b1, 2);
        stop_check(3, 3, 1'b1);
        i_inv = 1'b0;
        step();
        chk("b_idle_inv", o_clk, 1'b0);

        // Enable drop/re-assert inside STOPPING, then a real stop mid-high.
        i_en = 1'b1;
        step();
        for (int c = 0; c < 30; c++) begin
            e = (c < 24) ? ((c % 6) < 3) : 1'b0;
            chk("c_o_clk", o_clk, e);
            if (c == 1)  i_en = 1'b0;
            if (c == 3)  i_en = 1'b1;
            if (c == 19) i_en = 1'b0;
            step();
        end
        chk("c_busy", o_busy, 1'b0);

        // Request on a boundary cycle waits for the following boundary.
        write_idle(8'd3, 1'b0);
        i_en = 1'b1;
        step();
        chk("e_cnt0", o_clk, 1'b1);
        step();
        chk("e_cnt1", o_clk, 1'b1);
        step();
        chk("e_cnt2", o_clk, 1'b0);
        i_div = 8'd4; i_div_valid = 1'b1;
        step();
        i_div_valid = 1'b0;
        chk("e_ack_held", o_div_ack, 1'b0);
        chk("e_busy", o_busy, 1'b1);
        chk("e_p2_cnt0", o_clk, 1'b1);
        step();
        chk("e_p2_cnt1", o_clk, 1'b1);
        step();
        chk("e_p2_cnt2", o_clk, 1'b0);
        step();
        chk("e_ack", o_div_ack, 1'b1);
        measure(2, 2, 1'b0, 1);
        stop_check(2, 2, 1'b0);

        // Stop boundary applies the pending ratio and acks on entering IDLE.
        i_en = 1'b1;
        step();
        chk("f_cnt0", o_clk, 1'b1);
        i_en = 1'b0; i_div = 8'd2; i_div_valid = 1'b1;
        step();
        i_div_valid = 1'b0;
        chk("f_busy", o_busy, 1'b1);
        chk("f_cnt1", o_clk, 1'b1);
        step();
        chk("f_cnt2", o_clk, 1'b0);
        chk("f_ack_early", o_div_ack, 1'b0);
        step();
        chk("f_cnt3", o_clk, 1'b0);
        step();
        chk("f_ack", o_div_ack, 1'b1);
        chk("f_idle_o_clk", o_clk, 1'b0);
        chk("f_busy_clr", o_busy, 1'b0);
        step();
        chk("f_ack_pulse", o_div_ack, 1'b0);
        i_en = 1'b1;
        step();
        measure(1, 1, 1'b0, 2);
        stop_check(1, 1, 1'b0);

        // Reset with an update pending drops it and restores ratio 2.
        write_idle(8'd3, 1'b0);
        i_en = 1'b1;
        step();
        i_div = 8'd9; i_div_valid = 1'b1;
        step();
        i_div_valid = 1'b0;
        chk("d_busy", o_busy, 1'b1);
        i_rst = 1'b1; i_en = 1'b0; i_inv = 1'b1;
        step();
        chk("d_rst_o_clk", o_clk, 1'b0);
        chk("d_rst_busy", o_busy, 1'b0);
        chk("d_rst_ack", o_div_ack, 1'b0);
        i_rst = 1'b0; i_inv = 1'b0;
        step();
        chk("d_no_ack", o_div_ack, 1'b0);
        chk("d_busy_idle", o_busy, 1'b0);
        i_en = 1'b1;
        step();
        measure(1, 1, 1'b0, 2);
        stop_check(1, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
